// File: rtl/wb_host_initiator.sv
// wb_host_initiator
//   Single-outstanding Wishbone classic initiator. Turns a valid/ready command
//   stream into one bus cycle at a time and returns exactly one response per
//   command. Every output is registered.
//
//   Optional feature macro: WB_HOST_TIMEOUT_EN
//     defined   : a saturating counter aborts a bus cycle after TIMEOUT_CYCLES
//                 bus cycles without ack. The response then carries
//                 rsp_err_o=1 and rsp_dat_o=ERR_DATA.
//     undefined : BUS waits for ack indefinitely and rsp_err_o is tied to 0.
//
//   Parameters
//     TIMEOUT_CYCLES : bus cycles to wait for ack before aborting (1..65535)
//     ERR_DATA       : rsp_dat_o value for an aborted cycle
//
//   Ports
//     wb_clk_i, wb_rst_ni               clock, async active-low reset
//     cmd_valid_i / cmd_ready_o         command handshake
//     cmd_we_i, cmd_sel_i,
//     cmd_adr_i, cmd_dat_i              command payload
//     rsp_valid_o / rsp_ready_i         response handshake
//     rsp_dat_o, rsp_err_o              response payload
//     wbm_cyc_o, wbm_stb_o, wbm_we_o,
//     wbm_sel_o, wbm_adr_o, wbm_dat_o   Wishbone initiator outputs
//     wbm_ack_i, wbm_dat_i              Wishbone slave returns
module wb_host_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic accept;
  logic ack_hit;
  logic tmo_hit;
  logic cyc_q;

  // In IDLE cmd_ready_o is always high, so valid alone is the handshake.
  assign accept  = (state_q == S_IDLE) && cmd_valid_i;
  assign ack_hit = (state_q == S_BUS) && wbm_ack_i;

`ifdef WB_HOST_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt_q;

  // Ack takes priority over the terminal count.
  assign tmo_hit = (state_q == S_BUS) && !wbm_ack_i && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (accept) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == S_BUS) && (tmo_cnt_q != '1)) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rsp_err_o <= 1'b0;
    end else if (ack_hit) begin
      rsp_err_o <= 1'b0;
    end else if (tmo_hit) begin
      rsp_err_o <= 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_valid_i)        state_d = S_BUS;
      S_BUS:   if (ack_hit || tmo_hit) state_d = S_RESP;
      S_RESP:  if (rsp_ready_i)        state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // Registered outputs, loaded on the same transitions as the state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cmd_ready_o <= 1'b1;
      cyc_q       <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
    end else begin
      if (accept) begin
        cmd_ready_o <= 1'b0;
        cyc_q       <= 1'b1;
        wbm_we_o    <= cmd_we_i;
        wbm_sel_o   <= cmd_sel_i;
        wbm_adr_o   <= cmd_adr_i;
        wbm_dat_o   <= cmd_dat_i;
      end
      if (ack_hit) begin
        cyc_q       <= 1'b0;
        rsp_valid_o <= 1'b1;
        rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
      end else if (tmo_hit) begin
        cyc_q       <= 1'b0;
        rsp_valid_o <= 1'b1;
        rsp_dat_o   <= ERR_DATA;
      end
      // No bypass: the command side reopens only after the response handshake.
      if ((state_q == S_RESP) && rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
        cmd_ready_o <= 1'b1;
      end
    end
  end

  // A single register drives both so cyc and stb can never disagree.
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_host_initiator.sv
module tb_wb_host_initiator;

  localparam int          T    = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;
`ifdef WB_HOST_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack = 1'b0;
  logic [31:0] sdat = 32'h0BAD_0BAD;

  always #5 clk = ~clk;

  wb_host_initiator #(
    .TIMEOUT_CYCLES(T),
    .ERR_DATA      (ERRD)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_sel_i  (cmd_sel),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (wdat),
    .wbm_ack_i  (ack),
    .wbm_dat_i  (sdat)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Transaction-level reference: one command in flight, counted in bus cycles.
  bit          m_bus, m_rsp, m_we, m_err;
  int          m_age;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_wdat, m_rdat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bus <= 0; m_rsp <= 0; m_we <= 0; m_err <= 0; m_age <= 0;
      m_sel <= '0; m_adr <= '0; m_wdat <= '0; m_rdat <= '0;
    end else if (m_bus) begin
      m_age <= m_age + 1;
      if (ack) begin
        m_bus <= 0; m_rsp <= 1; m_err <= 0;
        m_rdat <= m_we ? 32'h0 : sdat;
      end else if (TMO_EN && (m_age + 1 == T)) begin
        m_bus <= 0; m_rsp <= 1; m_err <= 1;
        m_rdat <= ERRD;
      end
    end else if (m_rsp) begin
      if (rsp_ready) m_rsp <= 0;
    end else if (cmd_valid) begin
      m_bus <= 1; m_age <= 0;
      m_we <= cmd_we; m_sel <= cmd_sel; m_adr <= cmd_adr; m_wdat <= cmd_dat;
    end
  end

  always @(negedge clk) begin
    chk("m_cyc",       {31'b0, cyc},       {31'b0, m_bus});
    chk("m_stb",       {31'b0, stb},       {31'b0, m_bus});
    chk("m_cmd_ready", {31'b0, cmd_ready}, {31'b0, !m_bus && !m_rsp});
    chk("m_rsp_valid", {31'b0, rsp_valid}, {31'b0, m_rsp});
    if (m_bus) begin
      chk("m_we",  {31'b0, we},  {31'b0, m_we});
      chk("m_sel", {28'b0, sel}, {28'b0, m_sel});
      chk("m_adr", adr,  m_adr);
      chk("m_dat", wdat, m_wdat);
    end
    if (m_rsp) begin
      chk("m_rsp_dat", rsp_dat, m_rdat);
      chk("m_rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
    end
  end

  // Waits for cmd_ready, presents one command for one edge; returns just after
  // the accepting edge.
  task automatic send(input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_bound("send_ready");
    cmd_valid = 1'b1; cmd_we = w; cmd_sel = s; cmd_adr = a; cmd_dat = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Slave with ws wait states; counts cycles cyc was seen high.
  task automatic slave(input int ws, input logic [31:0] d, output int hi);
    hi = 0;
    for (int i = 0; i < ws; i++) begin
      if (cyc) hi++;
      @(negedge clk);
    end
    ack = 1'b1; sdat = d;
    if (cyc) hi++;
    @(negedge clk);
    ack = 1'b0; sdat = 32'h0BAD_0BAD;
  endtask

  initial begin
    int hi;
    int k;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_cyc",       {31'b0, cyc},       32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_dat",   rsp_dat,            32'd0);
    chk("rst_adr",       adr,                32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait write
    send(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_0001);
    chk("wr_cyc", {31'b0, cyc}, 32'd1);
    chk("wr_adr", adr,  32'h3000_0004);
    chk("wr_dat", wdat, 32'hA5A5_0001);
    chk("wr_sel", {28'b0, sel}, 32'hF);
    chk("wr_we",  {31'b0, we},  32'd1);
    slave(0, 32'hFFFF_FFFF, hi);
    chk("wr_cyc_cycles", hi, 32'd1);
    chk("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("wr_rsp_dat", rsp_dat, 32'd0);
    chk("wr_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    chk("wr_done_valid", {31'b0, rsp_valid}, 32'd0);
    chk("wr_done_ready", {31'b0, cmd_ready}, 32'd1);

    // Read with 3 wait states
    send(1'b0, 4'hF, 32'h3000_0010, 32'h0);
    slave(3, 32'h1234_5678, hi);
    chk("rd3_cyc_cycles", hi, 32'd4);
    chk("rd3_rsp_dat", rsp_dat, 32'h1234_5678);
    chk("rd3_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);

`ifdef WB_HOST_TIMEOUT_EN
    // Timeout, response held so a late ack can be shown to be ignored
    rsp_ready = 1'b0;
    send(1'b0, 4'h3, 32'h3000_0020, 32'h0);
    k = 0;
    while (cyc && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_edges", k, T);
    chk("tmo_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("tmo_rsp_err", {31'b0, rsp_err}, 32'd1);
    chk("tmo_rsp_dat", rsp_dat, 32'hDEADBEEF);
    @(negedge clk);
    ack = 1'b1; sdat = 32'h5555_AAAA;
    @(negedge clk);
    ack = 1'b0; sdat = 32'h0BAD_0BAD;
    chk("late_ack_dat", rsp_dat, 32'hDEADBEEF);
    chk("late_ack_err", {31'b0, rsp_err}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("tmo_done_valid", {31'b0, rsp_valid}, 32'd0);
`else
    // No timeout path: the cycle stays open until ack
    send(1'b0, 4'h3, 32'h3000_0020, 32'h0);
    repeat (20) @(negedge clk);
    chk("notmo_cyc", {31'b0, cyc}, 32'd1);
    chk("notmo_valid", {31'b0, rsp_valid}, 32'd0);
    slave(0, 32'h7777_0000, hi);
    chk("notmo_rsp_dat", rsp_dat, 32'h7777_0000);
    chk("notmo_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
`endif

    // Response backpressure with a second command waiting
    rsp_ready = 1'b0;
    send(1'b1, 4'h1, 32'h3000_0030, 32'h0000_00AA);
    slave(0, 32'h1111_1111, hi);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF;
    cmd_adr = 32'h3000_0040; cmd_dat = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_dat",   rsp_dat,            32'd0);
      chk("bp_ready", {31'b0, cmd_ready}, 32'd0);
      chk("bp_cyc",   {31'b0, cyc},       32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", {31'b0, rsp_valid}, 32'd0);
    chk("bp_hs_ready", {31'b0, cmd_ready}, 32'd1);
    chk("bp_hs_cyc",   {31'b0, cyc},       32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_next_cyc", {31'b0, cyc}, 32'd1);
    chk("bp_next_adr", adr, 32'h3000_0040);
    slave(1, 32'h0BEE_F00D, hi);
    chk("bp_next_dat", rsp_dat, 32'h0BEE_F00D);
    @(negedge clk);

    // Reset during the second bus cycle of a read
    send(1'b0, 4'hF, 32'h3000_0050, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_cyc",   {31'b0, cyc},       32'd0);
    chk("mrst_stb",   {31'b0, stb},       32'd0);
    chk("mrst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mrst_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b0, 4'hF, 32'h3000_0054, 32'h0);
    slave(2, 32'hCAFE_0001, hi);
    chk("post_rst_cycles", hi, 32'd3);
    chk("post_rst_dat", rsp_dat, 32'hCAFE_0001);
    @(negedge clk);

    // Ack on the terminal timeout cycle wins
    send(1'b0, 4'hF, 32'h3000_0060, 32'h0);
    slave(T - 1, 32'h600D_D00D, hi);
    chk("term_cycles", hi, T);
    chk("term_err", {31'b0, rsp_err}, 32'd0);
    chk("term_dat", rsp_dat, 32'h600D_D00D);
    @(negedge clk);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    fail_bound("watchdog");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
